i2c_regfile_ctrl: RTL and testbench

I2C_REGFILE_CTRL -- requirements
Module: i2c_regfile_ctrl

---
 rtl/i2c_regfile_ctrl.sv | 152 +++++++++++++++
 tb/tb_i2c_regfile_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile_ctrl.sv
// I2C-accessible 16 x 8-bit register file with a local request/ack port and a shared pointer.
// Optional I2C write lock on reg[15] bit 0 enabled by macro I2C_REGFILE_WRITE_PROTECT_EN.
module i2c_regfile_ctrl #(
  parameter int NUM_REGS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_read_req,
  output logic [7:0] i2c_data_to_master,
  input  logic       i2c_data_valid,
  input  logic [7:0] i2c_data_from_master,
  input  logic [7:0] i2c_write_cycle_count,
  input  logic       loc_req,
  input  logic       loc_we,
  input  logic [3:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  output logic       loc_ack,
  output logic [3:0] ptr
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOC  = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_t;

  arb_state_t state_r;
  arb_state_t state_next_s;

  logic [7:0] regs_r [NUM_REGS];
  logic [3:0] ptr_r;
  logic [3:0] ptr_next_s;
  logic       evt_r;
  logic [7:0] loc_rdata_r;
  logic       loc_ack_r;

  logic       load_s;
  logic       i2c_wr_s;
  logic       i2c_wr_en_s;
  logic       lock_drop_s;
  logic       loc_go_s;
  logic       loc_wr_s;
  logic       loc_rd_s;

  // The master byte is only stable one cycle after its valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_r <= 1'b0;
    end else begin
      evt_r <= i2c_data_valid;
    end
  end

  assign load_s   = evt_r && (i2c_write_cycle_count == 8'd1);
  assign i2c_wr_s = evt_r && (i2c_write_cycle_count >= 8'd2);

`ifdef I2C_REGFILE_WRITE_PROTECT_EN
  assign lock_drop_s = regs_r[15][0] && !ptr_r[3];
`else
  assign lock_drop_s = 1'b0;
`endif

  // A dropped (locked) I2C write still counts as a collision and still moves the pointer.
  assign i2c_wr_en_s = i2c_wr_s && !lock_drop_s;

  // Pointer priority: load, then one increment for a write or a read.
  always_comb begin
    if (load_s) begin
      ptr_next_s = i2c_data_from_master[3:0];
    end else if (i2c_wr_s || i2c_read_req) begin
      ptr_next_s = ptr_r + 4'd1;
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Arbiter next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (loc_req && !i2c_wr_s) begin
          state_next_s = ARB_LOC;
        end else begin
          state_next_s = ARB_IDLE;
        end
      end
      ARB_LOC: begin
        if (!i2c_wr_s) begin
          state_next_s = ARB_ACK;
        end else begin
          state_next_s = ARB_LOC;
        end
      end
      ARB_ACK: state_next_s = ARB_IDLE;
      default: state_next_s = ARB_IDLE;
    endcase
  end

  // Arbiter outputs: the local access proceeds only when no I2C write owns this edge.
  always_comb begin
    loc_go_s = 1'b0;
    case (state_r)
      ARB_IDLE: loc_go_s = 1'b0;
      ARB_LOC:  loc_go_s = !i2c_wr_s;
      ARB_ACK:  loc_go_s = 1'b0;
      default:  loc_go_s = 1'b0;
    endcase
  end

  assign loc_wr_s = loc_go_s && loc_we;
  assign loc_rd_s = loc_go_s && !loc_we;

  // Register file, pointer and local response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 8'h00;
      end
      ptr_r       <= 4'd0;
      loc_rdata_r <= 8'h00;
      loc_ack_r   <= 1'b0;
    end else begin
      if (i2c_wr_en_s) begin
        regs_r[ptr_r] <= i2c_data_from_master;
      end else if (loc_wr_s) begin
        regs_r[loc_addr] <= loc_wdata;
      end
      if (loc_rd_s) begin
        loc_rdata_r <= regs_r[loc_addr];
      end
      ptr_r     <= ptr_next_s;
      loc_ack_r <= loc_go_s;
    end
  end

  assign i2c_data_to_master = regs_r[ptr_r];
  assign loc_rdata          = loc_rdata_r;
  assign loc_ack            = loc_ack_r;
  assign ptr                = ptr_r;

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// Directed bench for i2c_regfile_ctrl: expectations are queued with the stimulus and popped at check points.
module tb_i2c_regfile_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i2c_read_req;
  logic [7:0] i2c_data_to_master;
  logic       i2c_data_valid;
  logic [7:0] i2c_data_from_master;
  logic [7:0] i2c_write_cycle_count;
  logic       loc_req;
  logic       loc_we;
  logic [3:0] loc_addr;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;
  logic       loc_ack;
  logic [3:0] ptr;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  i2c_regfile_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .i2c_read_req          (i2c_read_req),
    .i2c_data_to_master    (i2c_data_to_master),
    .i2c_data_valid        (i2c_data_valid),
    .i2c_data_from_master  (i2c_data_from_master),
    .i2c_write_cycle_count (i2c_write_cycle_count),
    .loc_req               (loc_req),
    .loc_we                (loc_we),
    .loc_addr              (loc_addr),
    .loc_wdata             (loc_wdata),
    .loc_rdata             (loc_rdata),
    .loc_ack               (loc_ack),
    .ptr                   (ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input logic [7:0] obs);
    logic [7:0] e;
    string      t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // One master byte: valid strobe, then the event cycle in which it takes effect.
  task automatic i2c_byte(input logic [7:0] b, input logic [7:0] cnt);
    i2c_data_valid        = 1'b1;
    i2c_data_from_master  = b;
    i2c_write_cycle_count = cnt;
    tick();
    i2c_data_valid = 1'b0;
    tick();
  endtask

  task automatic read_pulse();
    i2c_read_req = 1'b1;
    tick();
    i2c_read_req = 1'b0;
  endtask

  // Local access, optionally launching an I2C write strobe in the request cycle.
  task automatic loc_access(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                            input logic with_i2c, input logic [7:0] ib, input logic [7:0] icnt,
                            output logic [7:0] lat, output logic [7:0] rd);
    loc_req   = 1'b1;
    loc_we    = we;
    loc_addr  = addr;
    loc_wdata = wd;
    if (with_i2c) begin
      i2c_data_valid        = 1'b1;
      i2c_data_from_master  = ib;
      i2c_write_cycle_count = icnt;
    end
    lat = 8'd99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      i2c_data_valid = 1'b0;
      if (loc_ack) begin
        lat = 8'(n);
        break;
      end
    end
    rd = loc_rdata;
    loc_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] lat;
    logic [7:0] rd;
    int ack_seen;

    rst = 1'b1;
    i2c_read_req = 1'b0;
    i2c_data_valid = 1'b0;
    i2c_data_from_master = 8'h00;
    i2c_write_cycle_count = 8'h00;
    loc_req = 1'b0;
    loc_we = 1'b0;
    loc_addr = 4'd0;
    loc_wdata = 8'h00;
    repeat (3) tick();

    expect_val("reset_ptr", 8'h00);
    expect_val("reset_ack", 8'h00);
    expect_val("reset_dtm", 8'h00);
    expect_val("reset_rdata", 8'h00);
    check_next({4'h0, ptr});
    check_next({7'h00, loc_ack});
    check_next(i2c_data_to_master);
    check_next(loc_rdata);
    rst = 1'b0;
    tick();

    // Pointer load then two auto-incrementing writes.
    i2c_byte(8'h03, 8'd1);
    i2c_byte(8'hA5, 8'd2);
    i2c_byte(8'h5A, 8'd3);
    expect_val("wr_ptr5", 8'h05);
    check_next({4'h0, ptr});
    expect_val("rd3_lat", 8'd2);
    expect_val("rd3_val", 8'hA5);
    loc_access(1'b0, 4'd3, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(lat);
    check_next(rd);
    expect_val("rd4_val", 8'h5A);
    loc_access(1'b0, 4'd4, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(rd);

    // Read wrap 15 -> 0 -> 1.
    loc_access(1'b1, 4'd15, 8'h3C, 1'b0, 8'h00, 8'd0, lat, rd);
    loc_access(1'b1, 4'd0, 8'hC3, 1'b0, 8'h00, 8'd0, lat, rd);
    loc_access(1'b1, 4'd1, 8'h96, 1'b0, 8'h00, 8'd0, lat, rd);
    i2c_byte(8'h0F, 8'd1);
    expect_val("dtm_reg15", 8'h3C);
    check_next(i2c_data_to_master);
    read_pulse();
    expect_val("dtm_reg0", 8'hC3);
    expect_val("ptr_wrap0", 8'h00);
    check_next(i2c_data_to_master);
    check_next({4'h0, ptr});
    read_pulse();
    expect_val("dtm_reg1", 8'h96);
    expect_val("ptr_1", 8'h01);
    check_next(i2c_data_to_master);
    check_next({4'h0, ptr});

    // Uncontended local write.
    expect_val("wr2_lat", 8'd2);
    loc_access(1'b1, 4'd2, 8'h77, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(lat);
    expect_val("rd2_val", 8'h77);
    loc_access(1'b0, 4'd2, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(rd);

    // Local write colliding with an I2C write to the same register.
    i2c_byte(8'h06, 8'd1);
    expect_val("collide_lat", 8'd3);
    loc_access(1'b1, 4'd6, 8'h11, 1'b1, 8'h22, 8'd2, lat, rd);
    check_next(lat);
    expect_val("collide_ptr7", 8'h07);
    check_next({4'h0, ptr});
    expect_val("collide_reg6", 8'h11);
    loc_access(1'b0, 4'd6, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(rd);

    // Lock bit set locally, then an I2C write to reg 2.
    loc_access(1'b1, 4'd15, 8'h01, 1'b0, 8'h00, 8'd0, lat, rd);
    i2c_byte(8'h02, 8'd1);
    i2c_byte(8'hFF, 8'd2);
    expect_val("lock_ptr3", 8'h03);
    check_next({4'h0, ptr});
`ifdef I2C_REGFILE_WRITE_PROTECT_EN
    expect_val("lock_reg2", 8'h77);
`else
    expect_val("lock_reg2", 8'hFF);
`endif
    loc_access(1'b0, 4'd2, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(rd);
    loc_access(1'b1, 4'd15, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);

    // Write wrap 15 -> 0, then write and read increments in one cycle count once.
    i2c_byte(8'h0F, 8'd1);
    i2c_byte(8'hE1, 8'd2);
    expect_val("wr_wrap_ptr0", 8'h00);
    check_next({4'h0, ptr});
    i2c_data_valid        = 1'b1;
    i2c_data_from_master  = 8'h4B;
    i2c_write_cycle_count = 8'd3;
    tick();
    i2c_data_valid = 1'b0;
    i2c_read_req   = 1'b1;
    tick();
    i2c_read_req = 1'b0;
    expect_val("single_inc_ptr1", 8'h01);
    check_next({4'h0, ptr});
    expect_val("wr_wrap_reg15", 8'hE1);
    loc_access(1'b0, 4'd15, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(rd);

    // Reset while the arbiter is servicing a local write.
    loc_req   = 1'b1;
    loc_we    = 1'b1;
    loc_addr  = 4'd9;
    loc_wdata = 8'h55;
    tick();
    rst     = 1'b1;
    loc_req = 1'b0;
    ack_seen = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (loc_ack) ack_seen = 1;
    end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (loc_ack) ack_seen = 1;
    end
    expect_val("rst_no_ack", 8'h00);
    expect_val("rst_ptr0", 8'h00);
    expect_val("rst_dtm", 8'h00);
    check_next(8'(ack_seen));
    check_next({4'h0, ptr});
    check_next(i2c_data_to_master);
    expect_val("rst_reg9", 8'h00);
    loc_access(1'b0, 4'd9, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(rd);
    expect_val("rst_reg2", 8'h00);
    loc_access(1'b0, 4'd2, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(rd);
    expect_val("rst_reg15", 8'h00);
    loc_access(1'b0, 4'd15, 8'h00, 1'b0, 8'h00, 8'd0, lat, rd);
    check_next(rd);

    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
